// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: latches request edges into sticky pending bits and grants
// the highest unmasked pending line on a valid/ack handshake.
module irq_pending_arbiter #(
   parameter int N   = 8,
   parameter int IDW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   mask,
   input  logic           irq_ack,
   input  logic           ovr_clr,
   output logic           irq_valid,
   output logic [IDW-1:0] irq_id,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   overrun
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] VALID = 1'b1;
   logic [0:0]     state;
   logic [N-1:0]   req_q, rise, clr, avail, lost;
   logic [IDW-1:0] sel;
   assign rise  = req & ~req_q;
   assign clr   = (irq_valid & irq_ack) ? (N'(1) << irq_id) : '0;
   assign lost  = rise & pending & ~clr;
   assign avail = pending & ~mask;
   // ascending scan so the highest set index is the one left in sel
   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++)
         if (avail[i]) sel = IDW'(i);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         req_q   <= '0;
         pending <= '0;
         overrun <= '0;
      end else begin
         req_q   <= req;
         pending <= (pending & ~clr) | rise;
         overrun <= (ovr_clr ? '0 : overrun) | lost;
      end
   // grant is held without preemption until acknowledged
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
         irq_id    <= '0;
      end else if (state == IDLE) begin
         if (|avail) begin
            state     <= VALID;
            irq_valid <= 1'b1;
            irq_id    <= sel;
         end
      end else if (irq_ack) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
      end
endmodule
